// File: rtl/instr_sequencer_if.sv
// Bundle of sequencer connections to the ROM, decode unit, branch LUT, data memory
// and the start/done program handshake.
interface instr_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CYC_W = 16
);
  logic             start;
  logic             done;
  logic [PC_W-1:0]  pc;
  logic [8:0]       instr;
  logic [8:0]       ir;
  logic             halt;
  logic             branch_en;
  logic             mem_read;
  logic             mem_write;
  logic [PC_W-1:0]  target;
  logic             exec_en;
  logic             mem_req;
  logic             mem_ack;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    input  start, instr, halt, branch_en, mem_read, mem_write, target, mem_ack,
    output done, pc, ir, exec_en, mem_req, cycle_count
  );

  modport slave (
    output start, instr, halt, branch_en, mem_read, mem_write, target, mem_ack,
    input  done, pc, ir, exec_en, mem_req, cycle_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns pc and ir, qualifies commits with
// exec_en and stalls on the data-memory request/acknowledge handshake.
module instr_sequencer #(
  parameter int PC_W  = 10,
  parameter int CYC_W = 16
) (
  input logic                clk,
  input logic                reset,
  instr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_DONE
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc_q;
  logic [8:0]       ir_q;
  logic             done_q;
  logic [CYC_W-1:0] cyc_q;

  logic             mem_op;
  logic [PC_W-1:0]  pc_inc;
  logic [CYC_W-1:0] cyc_next;
  logic             exec_en;
  logic             mem_req;

  assign mem_op   = bus.mem_read | bus.mem_write;
  assign pc_inc   = pc_q + PC_W'(1);
  assign cyc_next = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);

  // Handshake qualifiers follow the state directly so a reset drops them at once.
  always_comb begin
    exec_en = 1'b0;
    mem_req = 1'b0;
    case (state)
      ST_EXEC: begin
        if (!bus.halt) begin
          if (mem_op) begin
            mem_req = 1'b1;
            exec_en = bus.mem_ack;
          end else begin
            exec_en = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        exec_en = bus.mem_ack;
      end
      default: begin
        exec_en = 1'b0;
        mem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc_q   <= '0;
      ir_q   <= '0;
      done_q <= 1'b0;
      cyc_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_FETCH;
            pc_q  <= '0;
            cyc_q <= '0;
          end
        end
        ST_FETCH: begin
          cyc_q <= cyc_next;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          cyc_q <= cyc_next;
          ir_q  <= bus.instr;
          state <= ST_EXEC;
        end
        // Priority is halt, then memory access, then branch or plain ALU step.
        ST_EXEC: begin
          cyc_q <= cyc_next;
          if (bus.halt) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else if (mem_op) begin
            if (bus.mem_ack) begin
              pc_q  <= pc_inc;
              state <= ST_FETCH;
            end else begin
              state <= ST_MEM_WAIT;
            end
          end else begin
            pc_q  <= bus.branch_en ? bus.target : pc_inc;
            state <= ST_FETCH;
          end
        end
        ST_MEM_WAIT: begin
          cyc_q <= cyc_next;
          if (bus.mem_ack) begin
            pc_q  <= pc_inc;
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            pc_q   <= '0;
            cyc_q  <= '0;
            done_q <= 1'b0;
            state  <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cyc_q;
  assign bus.exec_en     = exec_en;
  assign bus.mem_req     = mem_req;

endmodule
